// File: rtl/fetch_decode_alu_pkg.sv
// Shared definitions for the dual-issue front end: NOP word, RV32I opcodes,
// ALU operation encoding and the decoded-field bundle.
package fetch_decode_alu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SRA = 3'd7
  } alu_op_e;

  // Field order matters: the first member is the most significant slice.
  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } decoded_t;

endpackage

// File: rtl/alu_lane.sv
// One combinational integer ALU lane; add/sub wrap and no flags are produced.
module alu_lane
  import fetch_decode_alu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  // Shifts use only the low five bits of b as the shift amount.
  always_comb begin
    y = '0;
    case (alu_op_e'(op))
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLL: y = a << b[4:0];
      ALU_SRL: y = a >> b[4:0];
      ALU_SRA: y = $unsigned($signed(a) >>> b[4:0]);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/fetch_decode_alu_decode.sv
// Single-slot RV32I decoder: splits the word into fields, builds the
// sign-extended immediate and clears fields the format does not use.
module fetch_decode_alu_decode
  import fetch_decode_alu_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec
);

  // Raw field split first, then per-format immediate and field clearing.
  always_comb begin
    dec        = '0;
    dec.opcode = instr[6:0];
    dec.rd     = instr[11:7];
    dec.funct3 = instr[14:12];
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.funct7 = instr[31:25];
    dec.imm    = '0;
    case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        dec.imm = {{20{instr[31]}}, instr[31:20]};
        dec.rs2 = '0;
      end
      OPC_STORE: begin
        dec.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        dec.rd  = '0;
      end
      OPC_BRANCH: begin
        dec.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        dec.rd  = '0;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.imm = {instr[31:12], 12'b0};
        dec.rs1 = '0;
        dec.rs2 = '0;
      end
      OPC_JAL: begin
        dec.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        dec.rs1 = '0;
        dec.rs2 = '0;
      end
      OPC_OP: begin
        dec.imm = '0;
      end
      default: begin
        dec.rs1 = '0;
        dec.rs2 = '0;
        dec.rd  = '0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_decode_alu_fetch.sv
// Fetch unit: reads two consecutive ROM words per clock and stops for good
// at the first all-zero word or at the end of the ROM.
module fetch_decode_alu_fetch
  import fetch_decode_alu_pkg::*;
#(
  parameter int                       IMEM_DEPTH = 256,
  parameter logic [IMEM_DEPTH*32-1:0] IMEM_INIT  = '0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] instr1,
  output logic [31:0] instr2,
  output logic        finish
);

  // One extra PC bit so the PC can sit exactly at IMEM_DEPTH without wrapping.
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_PC = PW'(IMEM_DEPTH);

  logic [31:0]   rom [IMEM_DEPTH];
  logic [PW-1:0] pc;
  logic [PW-1:0] pc_plus1;
  logic [31:0]   word0;
  logic [31:0]   word1;

  // Word i of the image lives at bits [i*32 +: 32] of IMEM_INIT.
  for (genvar i = 0; i < IMEM_DEPTH; i++) begin : g_rom
    assign rom[i] = IMEM_INIT[i*32 +: 32];
  end

  assign pc_plus1 = pc + PW'(1);

  // Reads past the end of the ROM look like an end marker.
  always_comb begin
    word0 = '0;
    word1 = '0;
    if (pc < DEPTH_PC) begin
      word0 = rom[pc[AW-1:0]];
    end
    if (pc_plus1 < DEPTH_PC) begin
      word1 = rom[pc_plus1[AW-1:0]];
    end
  end

  // Issue one pair per cycle; on an end marker pad with NOPs and freeze.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= '0;
      instr1 <= NOP_INSTR;
      instr2 <= NOP_INSTR;
      finish <= 1'b0;
    end else if (finish) begin
      instr1 <= NOP_INSTR;
      instr2 <= NOP_INSTR;
    end else if (word0 == '0) begin
      instr1 <= NOP_INSTR;
      instr2 <= NOP_INSTR;
      finish <= 1'b1;
    end else if (word1 == '0) begin
      instr1 <= word0;
      instr2 <= NOP_INSTR;
      finish <= 1'b1;
    end else begin
      instr1 <= word0;
      instr2 <= word1;
      pc     <= pc + PW'(2);
    end
  end

endmodule

// File: rtl/fetch_decode_alu.sv
// Dual-issue front end: fetch unit feeding two decoders, plus two
// independent ALU lanes driven by the reservation station.
module fetch_decode_alu
  import fetch_decode_alu_pkg::*;
#(
  parameter int                       IMEM_DEPTH = 256,
  // Hex image the build scripts turn into IMEM_INIT for this instance.
  parameter string                    IMEM_FILE  = "program.mem",
  parameter logic [IMEM_DEPTH*32-1:0] IMEM_INIT  = '0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] instr1,
  output logic [31:0] instr2,
  output logic        finish,
  output logic [4:0]  instr1_rs1,
  output logic [4:0]  instr1_rs2,
  output logic [4:0]  instr1_rd,
  output logic [31:0] instr1_imm,
  output logic [2:0]  instr1_funct3,
  output logic [6:0]  instr1_funct7,
  output logic [6:0]  instr1_opcode,
  output logic [4:0]  instr2_rs1,
  output logic [4:0]  instr2_rs2,
  output logic [4:0]  instr2_rd,
  output logic [31:0] instr2_imm,
  output logic [2:0]  instr2_funct3,
  output logic [6:0]  instr2_funct7,
  output logic [6:0]  instr2_opcode,
  input  logic [2:0]  alu0_op,
  input  logic [31:0] alu0_a,
  input  logic [31:0] alu0_b,
  output logic [31:0] alu0_y,
  input  logic [2:0]  alu1_op,
  input  logic [31:0] alu1_a,
  input  logic [31:0] alu1_b,
  output logic [31:0] alu1_y
);

  decoded_t dec1;
  decoded_t dec2;

  fetch_decode_alu_fetch #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .IMEM_INIT  (IMEM_INIT)
  ) u_fetch (
    .clk    (clk),
    .rst    (rst),
    .instr1 (instr1),
    .instr2 (instr2),
    .finish (finish)
  );

  fetch_decode_alu_decode u_dec1 (
    .instr (instr1),
    .dec   (dec1)
  );

  fetch_decode_alu_decode u_dec2 (
    .instr (instr2),
    .dec   (dec2)
  );

  assign instr1_rs1    = dec1.rs1;
  assign instr1_rs2    = dec1.rs2;
  assign instr1_rd     = dec1.rd;
  assign instr1_imm    = dec1.imm;
  assign instr1_funct3 = dec1.funct3;
  assign instr1_funct7 = dec1.funct7;
  assign instr1_opcode = dec1.opcode;

  assign instr2_rs1    = dec2.rs1;
  assign instr2_rs2    = dec2.rs2;
  assign instr2_rd     = dec2.rd;
  assign instr2_imm    = dec2.imm;
  assign instr2_funct3 = dec2.funct3;
  assign instr2_funct7 = dec2.funct7;
  assign instr2_opcode = dec2.opcode;

  alu_lane u_alu0 (
    .op (alu0_op),
    .a  (alu0_a),
    .b  (alu0_b),
    .y  (alu0_y)
  );

  alu_lane u_alu1 (
    .op (alu1_op),
    .a  (alu1_a),
    .b  (alu1_b),
    .y  (alu1_y)
  );

endmodule

// File: tb/tb_fetch_decode_alu.sv
// Bench for fetch_decode_alu: two 4-word instances (one program ending in a
// zero word, one completely full ROM) plus a table of ALU vectors.
module tb_fetch_decode_alu;
  import fetch_decode_alu_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  alu0_op, alu1_op;
  logic [31:0] alu0_a, alu0_b, alu1_a, alu1_b;

  // Instance A outputs
  logic [31:0] a_instr1, a_instr2, a_imm1, a_imm2, a_y0, a_y1;
  logic        a_finish;
  logic [4:0]  a_rs1_1, a_rs2_1, a_rd_1, a_rs1_2, a_rs2_2, a_rd_2;
  logic [2:0]  a_f3_1, a_f3_2;
  logic [6:0]  a_f7_1, a_f7_2, a_op_1, a_op_2;

  // Instance B outputs
  logic [31:0] b_instr1, b_instr2, b_imm1, b_imm2, b_y0, b_y1;
  logic        b_finish;
  logic [4:0]  b_rs1_1, b_rs2_1, b_rd_1, b_rs1_2, b_rs2_2, b_rd_2;
  logic [2:0]  b_f3_1, b_f3_2;
  logic [6:0]  b_f7_1, b_f7_2, b_op_1, b_op_2;

  fetch_decode_alu #(
    .IMEM_DEPTH (4),
    .IMEM_INIT  ({32'h0000_0000, 32'h0020_81B3, 32'h00A0_0113, 32'h0050_0093})
  ) dut_a (
    .clk (clk), .rst (rst),
    .instr1 (a_instr1), .instr2 (a_instr2), .finish (a_finish),
    .instr1_rs1 (a_rs1_1), .instr1_rs2 (a_rs2_1), .instr1_rd (a_rd_1),
    .instr1_imm (a_imm1), .instr1_funct3 (a_f3_1), .instr1_funct7 (a_f7_1),
    .instr1_opcode (a_op_1),
    .instr2_rs1 (a_rs1_2), .instr2_rs2 (a_rs2_2), .instr2_rd (a_rd_2),
    .instr2_imm (a_imm2), .instr2_funct3 (a_f3_2), .instr2_funct7 (a_f7_2),
    .instr2_opcode (a_op_2),
    .alu0_op (alu0_op), .alu0_a (alu0_a), .alu0_b (alu0_b), .alu0_y (a_y0),
    .alu1_op (alu1_op), .alu1_a (alu1_a), .alu1_b (alu1_b), .alu1_y (a_y1)
  );

  fetch_decode_alu #(
    .IMEM_DEPTH (4),
    .IMEM_INIT  ({32'h1234_50B7, 32'h0080_006F, 32'hFE00_08E3, 32'hFE11_2E23})
  ) dut_b (
    .clk (clk), .rst (rst),
    .instr1 (b_instr1), .instr2 (b_instr2), .finish (b_finish),
    .instr1_rs1 (b_rs1_1), .instr1_rs2 (b_rs2_1), .instr1_rd (b_rd_1),
    .instr1_imm (b_imm1), .instr1_funct3 (b_f3_1), .instr1_funct7 (b_f7_1),
    .instr1_opcode (b_op_1),
    .instr2_rs1 (b_rs1_2), .instr2_rs2 (b_rs2_2), .instr2_rd (b_rd_2),
    .instr2_imm (b_imm2), .instr2_funct3 (b_f3_2), .instr2_funct7 (b_f7_2),
    .instr2_opcode (b_op_2),
    .alu0_op (alu0_op), .alu0_a (alu0_a), .alu0_b (alu0_b), .alu0_y (b_y0),
    .alu1_op (alu1_op), .alu1_a (alu1_a), .alu1_b (alu1_b), .alu1_y (b_y1)
  );

  // Observed decode bundles, packed in decoded_t field order.
  decoded_t a_s1, a_s2, b_s1, b_s2;
  assign a_s1 = {a_op_1, a_rd_1, a_f3_1, a_rs1_1, a_rs2_1, a_f7_1, a_imm1};
  assign a_s2 = {a_op_2, a_rd_2, a_f3_2, a_rs1_2, a_rs2_2, a_f7_2, a_imm2};
  assign b_s1 = {b_op_1, b_rd_1, b_f3_1, b_rs1_1, b_rs2_1, b_f7_1, b_imm1};
  assign b_s2 = {b_op_2, b_rd_2, b_f3_2, b_rs1_2, b_rs2_2, b_f7_2, b_imm2};

  typedef struct {
    logic [2:0]  op0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [2:0]  op1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [31:0] y0;
    logic [31:0] y1;
  } alu_vec_t;

  alu_vec_t vecs [7];

  int total  = 0;
  int passed = 0;

  function automatic decoded_t mk(input logic [6:0] op, input logic [4:0] rd,
                                  input logic [2:0] f3, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [6:0] f7,
                                  input logic [31:0] imm);
    decoded_t d;
    d.opcode = op; d.rd = rd; d.funct3 = f3; d.rs1 = rs1;
    d.rs2 = rs2; d.funct7 = f7; d.imm = imm;
    return d;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic check_dec(input string name, input decoded_t act, input decoded_t exp);
    check_output({name, ".opcode"}, 32'(act.opcode), 32'(exp.opcode));
    check_output({name, ".rd"},     32'(act.rd),     32'(exp.rd));
    check_output({name, ".funct3"}, 32'(act.funct3), 32'(exp.funct3));
    check_output({name, ".rs1"},    32'(act.rs1),    32'(exp.rs1));
    check_output({name, ".rs2"},    32'(act.rs2),    32'(exp.rs2));
    check_output({name, ".funct7"}, 32'(act.funct7), 32'(exp.funct7));
    check_output({name, ".imm"},    act.imm,         exp.imm);
  endtask

  task automatic apply_stimulus(input alu_vec_t v);
    alu0_op = v.op0; alu0_a = v.a0; alu0_b = v.b0;
    alu1_op = v.op1; alu1_a = v.a1; alu1_b = v.b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    decoded_t nop_d;
    nop_d = mk(7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);

    vecs[0] = '{3'd1, 32'd3,          32'd5,          3'd7, 32'h8000_0000, 32'd4,          32'hFFFF_FFFE, 32'hF800_0000};
    vecs[1] = '{3'd6, 32'h8000_0000,  32'd4,          3'd0, 32'hFFFF_FFFF, 32'd1,          32'h0800_0000, 32'h0000_0000};
    vecs[2] = '{3'd2, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  3'd3, 32'hF0F0_F0F0, 32'h0000_000F,  32'h00F0_00F0, 32'hF0F0_F0FF};
    vecs[3] = '{3'd4, 32'hAAAA_AAAA,  32'hFFFF_FFFF,  3'd5, 32'd1,         32'h0000_0023,  32'h5555_5555, 32'h0000_0008};
    vecs[4] = '{3'd0, 32'd7,          32'd8,          3'd1, 32'd0,         32'd1,          32'h0000_000F, 32'hFFFF_FFFF};
    vecs[5] = '{3'd7, 32'h7FFF_FFF0,  32'd4,          3'd6, 32'hFFFF_FFFF, 32'd31,         32'h07FF_FFFF, 32'h0000_0001};
    vecs[6] = '{3'd5, 32'hFFFF_FFFF,  32'd31,         3'd2, 32'h1234_5678, 32'hFFFF_0000,  32'h8000_0000, 32'h1234_0000};

    alu0_op = '0; alu0_a = '0; alu0_b = '0;
    alu1_op = '0; alu1_a = '0; alu1_b = '0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset.instr1", a_instr1, NOP);
    check_output("reset.instr2", a_instr2, NOP);
    check_output("reset.finish", 32'(a_finish), 32'd0);
    check_dec("reset.a_s1", a_s1, nop_d);
    check_output("reset.b_finish", 32'(b_finish), 32'd0);

    // Program A: addi, addi, add, end marker. Program B: full ROM.
    rst = 1'b0;
    step();
    check_output("c1.a_instr1", a_instr1, 32'h0050_0093);
    check_output("c1.a_instr2", a_instr2, 32'h00A0_0113);
    check_output("c1.a_finish", 32'(a_finish), 32'd0);
    check_dec("c1.a_s1", a_s1, mk(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5));
    check_dec("c1.a_s2", a_s2, mk(7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd10));
    check_output("c1.b_instr1", b_instr1, 32'hFE11_2E23);
    check_dec("c1.b_s1", b_s1, mk(7'h23, 5'd0, 3'd2, 5'd2, 5'd1, 7'h7F, 32'hFFFF_FFFC));
    check_dec("c1.b_s2", b_s2, mk(7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h7F, 32'hFFFF_FFF0));

    step();
    check_output("c2.a_instr1", a_instr1, 32'h0020_81B3);
    check_output("c2.a_instr2", a_instr2, NOP);
    check_output("c2.a_finish", 32'(a_finish), 32'd1);
    check_dec("c2.a_s1", a_s1, mk(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0));
    check_dec("c2.a_s2", a_s2, nop_d);
    check_output("c2.b_finish", 32'(b_finish), 32'd0);
    check_dec("c2.b_s1", b_s1, mk(7'h6F, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd8));
    check_dec("c2.b_s2", b_s2, mk(7'h37, 5'd1, 3'd5, 5'd0, 5'd0, 7'd9, 32'h1234_5000));

    step();
    check_output("c3.a_instr1", a_instr1, NOP);
    check_output("c3.a_instr2", a_instr2, NOP);
    check_output("c3.a_finish", 32'(a_finish), 32'd1);
    check_output("c3.b_instr1", b_instr1, NOP);
    check_output("c3.b_instr2", b_instr2, NOP);
    check_output("c3.b_finish", 32'(b_finish), 32'd1);

    step();
    check_output("c4.b_instr1_nowrap", b_instr1, NOP);
    check_output("c4.b_instr2_nowrap", b_instr2, NOP);
    check_output("c4.b_finish", 32'(b_finish), 32'd1);
    check_output("c4.a_finish", 32'(a_finish), 32'd1);

    // Restart, then reset asynchronously in the middle of a run
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    step();
    check_output("restart.a_instr1", a_instr1, 32'h0050_0093);
    check_output("restart.a_finish", 32'(a_finish), 32'd0);
    @(negedge clk); rst = 1'b1;
    #1;
    check_output("midrst.a_instr1", a_instr1, NOP);
    check_output("midrst.a_instr2", a_instr2, NOP);
    check_output("midrst.a_finish", 32'(a_finish), 32'd0);
    check_output("midrst.s1_rs1", 32'(a_rs1_1), 32'd0);
    check_output("midrst.s1_rd", 32'(a_rd_1), 32'd0);
    check_output("midrst.s1_imm", a_imm1, 32'd0);
    @(negedge clk); rst = 1'b0;
    step();
    check_output("postrst.a_instr1", a_instr1, 32'h0050_0093);
    check_output("postrst.a_instr2", a_instr2, 32'h00A0_0113);
    check_output("postrst.b_instr1", b_instr1, 32'hFE11_2E23);

    // ALU vectors, both lanes at once, on both instances
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("alu[%0d].a_y0", i), a_y0, vecs[i].y0);
      check_output($sformatf("alu[%0d].a_y1", i), a_y1, vecs[i].y1);
      check_output($sformatf("alu[%0d].b_y0", i), b_y0, vecs[i].y0);
      check_output($sformatf("alu[%0d].b_y1", i), b_y1, vecs[i].y1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
